// File: rtl/cipher_pkg.sv
// Shared constants and enumerations for the streaming Caesar/Vigenere cipher.
// Character bounds are 8-bit so comparisons against in_data need no width casts.
package cipher_pkg;

    localparam logic [7:0] ALPHA_LEN = 8'd26;
    localparam logic [7:0] UPPER_A   = 8'd65;
    localparam logic [7:0] UPPER_Z   = 8'd90;
    localparam logic [7:0] LOWER_A   = 8'd97;
    localparam logic [7:0] LOWER_Z   = 8'd122;

    typedef enum logic {
        ENCRYPT = 1'b0,
        DECRYPT = 1'b1
    } mode_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_e;

endpackage

// File: rtl/caesar_rot.sv
// Combinational single-character rotation: letters shift by key mod 26 within
// their own case, every other byte passes through unchanged.
module caesar_rot
    import cipher_pkg::*;
#(
    parameter int KEY_W = 5
) (
    input  logic [7:0]       ch_in,
    input  logic [KEY_W-1:0] key,
    input  mode_e            mode,
    output logic [7:0]       ch_out
);

    logic [7:0] k;
    logic [7:0] base;
    logic [7:0] off;
    logic [7:0] sum;
    logic       is_upper;
    logic       is_lower;

    // NOTE: sum is written twice in this block; blocking assignment is what makes
    // the second line see the first, and it is safe only because nothing here is stored.
    always_comb begin
        k        = 8'(key) % ALPHA_LEN;
        is_upper = (ch_in >= UPPER_A) && (ch_in <= UPPER_Z);
        is_lower = (ch_in >= LOWER_A) && (ch_in <= LOWER_Z);
        base     = is_upper ? UPPER_A : LOWER_A;
        off      = ch_in - base;
        sum      = (mode == ENCRYPT) ? off + k : off + (ALPHA_LEN - k);
        if (sum >= ALPHA_LEN) begin
            sum = sum - ALPHA_LEN;
        end
        ch_out   = (is_upper || is_lower) ? base + sum : ch_in;
    end

endmodule

// File: rtl/cipher_stream.sv
// Streaming cipher: one-entry output register with ready/valid on both sides and a
// writable key table stepped per accepted character (Vigenere when key_len > 1).
module cipher_stream
    import cipher_pkg::*;
#(
    parameter  int KEY_W     = 5,
    parameter  int KEY_DEPTH = 4,
    localparam int AW        = $clog2(KEY_DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sop,
    input  logic             select,
    input  logic             key_we,
    input  logic [AW-1:0]    key_addr,
    input  logic [KEY_W-1:0] key_din,
    input  logic [AW:0]      key_len,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(KEY_DEPTH);
    localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

    ostate_e          state;
    ostate_e          state_nxt;
    logic [AW-1:0]    idx;
    logic [AW-1:0]    cur_idx;
    logic [AW-1:0]    idx_nxt;
    logic [AW:0]      eff_len;
    logic [AW:0]      idx_inc;
    logic [KEY_W-1:0] key_table [KEY_DEPTH];
    logic [7:0]       rot_out;
    logic             accept;
    logic             consume;

    assign out_valid = (state == FULL);
    assign in_ready  = !RST && ((state == EMPTY) || out_ready);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    // An index left beyond a shortened key_len falls back to entry 0.
    always_comb begin
        if (key_len == '0) begin
            eff_len = LEN_ONE;
        end else if (key_len > DEPTH_L) begin
            eff_len = DEPTH_L;
        end else begin
            eff_len = key_len;
        end
        cur_idx = (in_sop || ({1'b0, idx} >= eff_len)) ? '0 : idx;
        idx_inc = {1'b0, cur_idx} + LEN_ONE;
        idx_nxt = (idx_inc >= eff_len) ? '0 : idx_inc[AW-1:0];
    end

    caesar_rot #(
        .KEY_W (KEY_W)
    ) u_rot (
        .ch_in  (in_data),
        .key    (key_table[cur_idx]),
        .mode   (mode_e'(select)),
        .ch_out (rot_out)
    );

    // NOTE: state_nxt gets its default before any branch, so every path assigns it
    // and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = FULL;
        end else if (consume) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= EMPTY;
            out_data <= '0;
            idx      <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                out_data <= rot_out;
                idx      <= idx_nxt;
            end
        end
    end

    // NOTE: the key table is a plain flop array, so reset can clear every entry;
    // a RAM-based table could not be cleared this way.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < KEY_DEPTH; i++) begin
                key_table[i] <= '0;
            end
        end else if (key_we) begin
            key_table[key_addr] <= key_din;
        end
    end

endmodule

// File: tb/tb_cipher_stream.sv
// Self-checking bench for cipher_stream: a per-cycle reference model plus
// directed vectors with hand-computed character results.
module tb_cipher_stream;

    localparam int KEY_W     = 5;
    localparam int KEY_DEPTH = 4;
    localparam int AW        = $clog2(KEY_DEPTH);

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [7:0]       in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_sop = 1'b0;
    logic             select = 1'b0;
    logic             key_we = 1'b0;
    logic [AW-1:0]    key_addr = '0;
    logic [KEY_W-1:0] key_din = '0;
    logic [AW:0]      key_len = 3'd1;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int mq[$];
    int got[$];
    int mkey [KEY_DEPTH];
    int midx = 0;

    cipher_stream #(
        .KEY_W     (KEY_W),
        .KEY_DEPTH (KEY_DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .select    (select),
        .key_we    (key_we),
        .key_addr  (key_addr),
        .key_din   (key_din),
        .key_len   (key_len),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rot(input int c, input int key, input int dec);
        int k;
        int base;
        k = key % 26;
        if (c >= 65 && c <= 90) base = 65;
        else if (c >= 97 && c <= 122) base = 97;
        else return c;
        return dec ? base + (c - base + 26 - k) % 26 : base + (c - base + k) % 26;
    endfunction

    function automatic int active_len(input int l);
        if (l == 0) return 1;
        if (l > KEY_DEPTH) return KEY_DEPTH;
        return l;
    endfunction

    // Reference model: checks outputs before each edge, then advances to the post-edge state.
    initial begin
        foreach (mkey[i]) mkey[i] = 0;
    end

    always @(negedge CLK) begin
        int exp_valid;
        int exp_ready;
        int len;
        int cur;
        exp_valid = (mq.size() > 0);
        exp_ready = !RST && (!exp_valid || out_ready);
        check("out_valid", out_valid, exp_valid);
        if (exp_valid) check("out_data", out_data, mq[0]);
        check("in_ready", in_ready, exp_ready);
        if (RST) begin
            mq.delete();
            foreach (mkey[i]) mkey[i] = 0;
            midx = 0;
        end else begin
            if (exp_valid && out_ready) begin
                got.push_back(int'(out_data));
                void'(mq.pop_front());
            end
            if (in_valid && exp_ready) begin
                len = active_len(int'(key_len));
                cur = (in_sop || midx >= len) ? 0 : midx;
                mq.push_back(rot(int'(in_data), mkey[cur], int'(select)));
                midx = (cur + 1) % len;
            end
            if (key_we) mkey[int'(key_addr)] = int'(key_din);
        end
    end

    task automatic wr_key(input int addr, input int val);
        key_we   = 1'b1;
        key_addr = AW'(addr);
        key_din  = KEY_W'(val);
        @(posedge CLK); #1;
        key_we   = 1'b0;
    endtask

    task automatic send(input int ch, input int sel, input int sop);
        int cnt;
        cnt      = 0;
        in_data  = 8'(ch);
        select   = sel[0];
        in_sop   = sop[0];
        in_valid = 1'b1;
        @(negedge CLK);
        while (!in_ready && cnt < 50) begin
            @(negedge CLK);
            cnt++;
        end
        check("send_ready", in_ready, 1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic drain(input string name, input int n);
        int cnt;
        cnt = 0;
        while (got.size() < n && cnt < 100) begin
            @(posedge CLK); #2;
            cnt++;
        end
        repeat (2) begin
            @(posedge CLK); #1;
        end
        check({name, "_count"}, got.size(), n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int cnt;

        repeat (2) begin
            @(posedge CLK); #1;
        end
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        check("ready_after_rst", in_ready, 1);

        // Single key, encrypt/decrypt and case handling.
        wr_key(0, 3);
        key_len = 3'd1;
        got.delete();
        send(65, 0, 1);
        send(68, 1, 0);
        send(99, 0, 0);
        drain("basic", 3);
        check("basic_0", got[0], 68);
        check("basic_1", got[1], 65);
        check("basic_2", got[2], 102);

        got.delete();
        send(90, 0, 1);
        send(97, 1, 0);
        send(33, 0, 0);
        drain("wrap", 3);
        check("wrap_0", got[0], 67);
        check("wrap_1", got[1], 120);
        check("wrap_2", got[2], 33);

        // Key 29 must behave exactly like key 3.
        wr_key(0, 29);
        got.delete();
        send(65, 0, 1);
        send(90, 0, 0);
        send(97, 1, 0);
        send(33, 0, 0);
        drain("mod", 4);
        check("mod_0", got[0], 68);
        check("mod_1", got[1], 67);
        check("mod_2", got[2], 120);
        check("mod_3", got[3], 33);

        // Vigenere with two keys, mid-stream restart, non-letter consuming a slot.
        wr_key(0, 1);
        wr_key(1, 2);
        key_len = 3'd2;
        got.delete();
        for (int i = 0; i < 4; i++) send(65, 0, (i == 0) ? 1 : 0);
        for (int i = 0; i < 4; i++) send(65, 0, (i == 0 || i == 2) ? 1 : 0);
        send(65, 0, 1);
        send(32, 0, 0);
        send(65, 0, 0);
        drain("vig", 11);
        check("vig_0", got[0], 66);
        check("vig_1", got[1], 67);
        check("vig_2", got[2], 66);
        check("vig_3", got[3], 67);
        check("vig_sop_2", got[6], 66);
        check("vig_sop_3", got[7], 67);
        check("vig_space", got[9], 32);
        check("vig_after_space", got[10], 66);

        // Shrinking key_len below the current index restarts at entry 0.
        wr_key(2, 4);
        wr_key(3, 5);
        key_len = 3'd3;
        got.delete();
        send(65, 0, 1);
        send(65, 0, 0);
        key_len = 3'd2;
        send(65, 0, 0);
        send(65, 0, 0);
        drain("shrink", 4);
        check("shrink_2", got[2], 66);
        check("shrink_3", got[3], 67);

        // key_len above depth clamps to 4; key_len 0 acts as 1.
        key_len = 3'd7;
        got.delete();
        for (int i = 0; i < 5; i++) send(65, 0, (i == 0) ? 1 : 0);
        key_len = 3'd0;
        send(65, 0, 1);
        send(65, 0, 0);
        drain("clamp", 7);
        check("clamp_2", got[2], 69);
        check("clamp_3", got[3], 70);
        check("clamp_4", got[4], 66);
        check("len0_1", got[6], 66);

        // Backpressure: output held for 5 cycles, then one character per cycle.
        key_len   = 3'd2;
        out_ready = 1'b0;
        got.delete();
        send(65, 0, 1);
        in_data  = 8'd65;
        in_sop   = 1'b0;
        select   = 1'b0;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge CLK); #1;
        end
        check("bp_hold_ready", in_ready, 0);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data", out_data, 66);
        out_ready = 1'b1;
        t0 = cyc;
        send(65, 0, 0);
        send(65, 0, 0);
        send(65, 0, 0);
        cnt = 0;
        while (got.size() < 4 && cnt < 50) begin
            @(posedge CLK); #2;
            cnt++;
        end
        check("bp_cycles", cyc - t0, 4);
        drain("bp", 4);
        check("bp_1", got[1], 67);
        check("bp_3", got[3], 67);

        // Key write in the same cycle as an accept uses the old entry.
        wr_key(0, 3);
        key_len = 3'd1;
        got.delete();
        key_we   = 1'b1;
        key_addr = '0;
        key_din  = 5'd5;
        send(65, 0, 1);
        key_we = 1'b0;
        send(65, 0, 0);
        drain("hazard", 2);
        check("hazard_0", got[0], 68);
        check("hazard_1", got[1], 70);

        // Reset while FULL discards the held character and clears the key table;
        // a key write during reset has no effect.
        out_ready = 1'b0;
        got.delete();
        send(65, 0, 1);
        RST      = 1'b1;
        key_we   = 1'b1;
        key_addr = '0;
        key_din  = 5'd7;
        @(posedge CLK); #1;
        RST    = 1'b0;
        key_we = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);
        out_ready = 1'b1;
        send(65, 0, 1);
        drain("midrst", 1);
        check("midrst_key0", got[0], 65);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cipher_stream.md
CIPHER_STREAM -- requirements
Module: cipher_stream

Interface
REQ-001 Parameter KEY_W, default 5, key-entry width in bits; legal range 1..8.
REQ-002 Parameter KEY_DEPTH, default 4, number of key-table entries; power of two, at least 2.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  8  ASCII character to process.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_sop  input  1  start-of-message flag, qualified by in_valid.
REQ-009 select  input  1  0 = encrypt, 1 = decrypt; sampled per accepted character.
REQ-010 key_we  input  1  key-table write strobe.
REQ-011 key_addr  input  clog2(KEY_DEPTH)  key-table write address.
REQ-012 key_din  input  KEY_W  key-table write data.
REQ-013 key_len  input  clog2(KEY_DEPTH)+1  active key count; 0 is treated as 1, values above KEY_DEPTH are clamped to KEY_DEPTH.
REQ-014 out_data  output  8  processed character.
REQ-015 out_valid  output  1  out_data valid.
REQ-016 out_ready  input  1  downstream accepts out_data.

Function
REQ-017 A transfer occurs when in_valid && in_ready; out_data is consumed when out_valid && out_ready.
REQ-018 The output register has two states, EMPTY and FULL. An accept moves it to FULL; a consume without an accept moves it to EMPTY; a simultaneous accept and consume keeps it FULL with the new data.
REQ-019 in_ready = (state EMPTY) || out_ready. Latency from accept to out_valid is exactly 1 cycle. Full throughput is one character per cycle.
REQ-020 While out_valid && !out_ready, out_data and out_valid hold stable.
REQ-021 Effective shift k = key_table[idx] mod 26, computed as an unsigned value in 0..25.
REQ-022 Uppercase input (65..90), encrypt: out = 65 + ((c-65+k) mod 26). Decrypt: out = 65 + ((c-65+26-k) mod 26).
REQ-023 Lowercase input (97..122) uses the same rule with base 97.
REQ-024 All other byte values pass through unchanged.
REQ-025 Key index idx selects the key entry for the current character. On each accept it advances by 1 and wraps to 0 after key_len-1, for letters and non-letters alike.
REQ-026 An accept with in_sop=1 uses idx=0 for that character; the next character then uses idx=1, or idx=0 if key_len is 1.
REQ-027 If key_len changes so that idx >= key_len, the next accept uses idx=0.
REQ-028 key_we writes key_din to key_table[key_addr] at the clock edge. An accept in the same cycle uses the old entry; the new value applies from the next cycle.
REQ-029 key_we is independent of the handshake and may occur at any time.

Reset
REQ-030 While RST=1 the block drives: out_valid=0, out_data=0, state=EMPTY, idx=0, and every key_table entry=0.
REQ-031 in_ready=0 while RST=1 and is 1 in the first cycle after RST falls.
REQ-032 RST asserted mid-message discards any held output with no partial output, and restarts the key index at 0.
REQ-033 A key_we in the same cycle as RST=1 is ignored.

Structure
REQ-034 Package cipher_pkg holds: ALPHA_LEN=26; ASCII bounds UPPER_A=65, UPPER_Z=90, LOWER_A=97, LOWER_Z=122; mode enum {ENCRYPT=0, DECRYPT=1}; output-state enum {EMPTY, FULL}.
REQ-035 Sub-module caesar_rot is purely combinational: (char, k, mode) -> char, implementing REQ-021..024. It is instantiated once.
REQ-036 The key table is a flop array of KEY_DEPTH x KEY_W bits; no memory macro.

Verification
REQ-037 key[0]=3, key_len=1, encrypt 'A'(65) -> 'D'(68); decrypt 68 -> 65; encrypt 'c'(99) -> 'f'(102); each out_valid exactly 1 cycle after accept.
REQ-038 Wrap and modulo: key[0]=3, encrypt 'Z'(90) -> 'C'(67), decrypt 'a'(97) -> 'x'(120); key[0]=29 gives results identical to key 3; encrypt '!'(33) -> 33.
REQ-039 Vigenere: key={1,2}, key_len=2, encrypt "AAAA" -> "BCBC". A mid-stream in_sop on the third 'A' gives "BCBC" with index restart. A space (32) between letters consumes a key slot.
REQ-040 Backpressure: hold out_ready=0 for 5 cycles with a stream pending. Required: out_data stable, in_ready=0 while FULL, no loss or duplication. Then out_ready=1 gives 1 char/cycle.
REQ-041 Key write hazard: key_we writes key[0]=5 in the same cycle 'A' is accepted with old key 3. Required: 'D' is output, and the next 'A' (key_len=1) yields 'F'(70).
REQ-042 Reset mid-message: assert RST while FULL. Required: out_valid=0 next cycle, key table zeroed, and the following 'A' with key 0 outputs 65.
